// File: rtl/deco7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: segment encoding,
// slot state type and the nibble-to-segment lookup.
package deco7seg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Each digit slot opens with an all-off gap before the digit is lit.
    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

    // Segment order is {a,b,c,d,e,f,g}, active-low.
    function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/deco_7seg_mux_scan_hex.sv
// Combinational nibble to active-low 7-segment decode.
module deco_hex_7seg
    import deco7seg_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/deco_7seg_mux_scan.sv
// Time-multiplexed common-anode 7-segment driver: prescaled digit scan with
// per-slot blanking, leading-zero suppression and frame-aligned value update.
module deco_7seg_mux_scan
    import deco7seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16,
    parameter int LZB_EN    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_valor,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    input  logic                  i_enable,
    output logic [SEG_W-1:0]      o_segmentos,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_anodos,
    output logic                  o_frame
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam slot_state_e   SLOT_RST  = (BLANK_CYC > 0) ? SLOT_BLANK : SLOT_SHOW;

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    slot_state_e             slot_q, slot_d;
    logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*N_DIGITS-1:0]   act_val_q, act_val_d;
    logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    wrap;
    logic [3:0]              act_nib [N_DIGITS];
    logic [N_DIGITS-1:0]     lz_blank;
    logic [3:0]              cur_nib;
    logic [SEG_W-1:0]        cur_seg;

    // Scan counters; the slot state tracks the prescaler value it will hold next.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        frame_d = wrap;
        slot_d  = (presc_d < BLANK_LIM) ? SLOT_BLANK : SLOT_SHOW;
    end

    // Displayed value only changes on the frame wrap so a frame never mixes two values.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        if (i_load) begin
            pend_val_d = i_valor;
            pend_dp_d  = i_dp;
        end
        if (wrap) begin
            act_val_d = i_load ? i_valor : pend_val_q;
            act_dp_d  = i_load ? i_dp    : pend_dp_q;
        end
    end

    always_comb begin
        for (int k = 0; k < N_DIGITS; k++) begin
            act_nib[k] = act_val_q[4*k +: 4];
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (act_nib[k] == 4'h0);
            if ((k > 0) && (LZB_EN != 0)) begin
                lz_blank[k] = zero_above;
            end
        end
    end

    assign cur_nib = act_nib[idx_q];

    deco_hex_7seg u_dec (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
        if (i_enable && (slot_q == SLOT_SHOW)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank[idx_q] ? SEG_OFF : cur_seg;
            dp_d        = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            slot_q     <= SLOT_RST;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= '1;
            frame_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign o_segmentos = seg_q;
    assign o_dp        = dp_q;
    assign o_anodos    = an_q;
    assign o_frame     = frame_q;

endmodule

// File: tb/tb_deco_7seg_mux_scan.sv
// Bench for deco_7seg_mux_scan: cycle-accurate reference model plus literal frame checks.
module tb_deco_7seg_mux_scan;

  localparam int ND    = 4;
  localparam int DV    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DV;
  localparam logic [6:0] OFF = 7'b1111111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] valor = '0;
  logic [3:0]  dpi = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fr_a, fr_b;
  logic [3:0] an_a, an_b;

  deco_7seg_mux_scan #(.N_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC), .LZB_EN(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valor(valor), .i_dp(dpi), .i_load(load),
    .i_enable(enable), .o_segmentos(seg_a), .o_dp(dp_a), .o_anodos(an_a), .o_frame(fr_a)
  );

  deco_7seg_mux_scan #(.N_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC), .LZB_EN(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valor(valor), .i_dp(dpi), .i_load(load),
    .i_enable(enable), .o_segmentos(seg_b), .o_dp(dp_b), .o_anodos(an_b), .o_frame(fr_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: scan position is simply the cycle count since reset
  logic [6:0]  seg_tab [16];
  logic [15:0] act_v, pend_v;
  logic [3:0]  act_dp, pend_dp;
  logic [6:0]  e_seg, e_seg_n;
  logic [3:0]  e_an;
  logic        e_dp, e_frame;
  bit          mdl_ok = 0;

  initial begin
    int unsigned cnt;
    int ph, pr, dg;
    logic [3:0] nib;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cnt = 0; act_v = '0; pend_v = '0; act_dp = '0; pend_dp = '0;
        e_seg = OFF; e_seg_n = OFF; e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
      end else begin
        ph = int'(cnt % FRAME);
        pr = ph % DV;
        dg = ph / DV;
        e_seg = OFF; e_seg_n = OFF; e_an = 4'hF; e_dp = 1'b1;
        if (enable && pr >= BC) begin
          nib     = 4'(act_v >> (4 * dg));
          e_an    = ~(4'b0001 << dg);
          e_seg_n = seg_tab[nib];
          e_seg   = (dg > 0 && (act_v >> (4 * dg)) == 16'h0) ? OFF : seg_tab[nib];
          e_dp    = ~act_dp[dg];
        end
        e_frame = (ph == FRAME - 1);
        if (ph == FRAME - 1) begin
          act_v  = load ? valor : pend_v;
          act_dp = load ? dpi : pend_dp;
        end
        if (load) begin
          pend_v  = valor;
          pend_dp = dpi;
        end
        cnt++;
      end
    end
  end

  // compare process, plus frame-period monitor
  initial begin
    int cyc;
    int last_fr;
    cyc = 0;
    last_fr = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_fr = -1;
      end else if (mdl_ok) begin
        chk("seg", 16'(seg_a), 16'(e_seg));
        chk("dp", 16'(dp_a), 16'(e_dp));
        chk("an", 16'(an_a), 16'(e_an));
        chk("frame", 16'(fr_a), 16'(e_frame));
        chk("seg_nolzb", 16'(seg_b), 16'(e_seg_n));
        chk("an_nolzb", 16'(an_b), 16'(e_an));
        chk("dp_nolzb", 16'(dp_b), 16'(e_dp));
        chk("frame_nolzb", 16'(fr_b), 16'(e_frame));
        if (fr_a) begin
          if (last_fr >= 0) chk("frame_period", 16'(cyc - last_fr), 16'(FRAME));
          last_fr = cyc;
        end
      end
    end
  end

  // scoreboard of literal per-slot expectations: {anodes, dp, segments}
  logic [11:0] exp_q[$];
  logic [6:0]  expb_q[$];

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      seen = fr_a;
    end
    chk("frame_seen", 16'(seen), 16'd1);
  endtask

  task automatic grab_frame(input bit at_frame);
    logic [11:0] e;
    logic [6:0]  eb;
    if (!at_frame) wait_frame();
    repeat (5) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("slot%0d", k), 16'({an_a, dp_a, seg_a}), 16'(e));
      end
      if (expb_q.size() > 0) begin
        eb = expb_q.pop_front();
        chk($sformatf("slot%0d_nolzb", k), 16'(seg_b), 16'(eb));
      end
      repeat (DV) @(negedge clk);
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    valor = v;
    dpi   = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic check_startup(input string tag);
    @(negedge clk);
    chk({tag, "_c1_an"}, 16'(an_a), 16'hF);
    chk({tag, "_c1_seg"}, 16'(seg_a), 16'(OFF));
    @(negedge clk);
    chk({tag, "_c2_seg"}, 16'(seg_a), 16'(OFF));
    @(negedge clk);
    chk({tag, "_c3_an"}, 16'(an_a), 16'b1110);
    chk({tag, "_c3_seg"}, 16'(seg_a), 16'b0000001);
  endtask

  initial begin
    int dark;
    bit found;
    repeat (3) @(posedge clk);
    #1;
    mdl_ok = 1;
    chk("rst_seg", 16'(seg_a), 16'(OFF));
    chk("rst_an", 16'(an_a), 16'hF);
    chk("rst_dp", 16'(dp_a), 16'd1);
    chk("rst_frame", 16'(fr_a), 16'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // power-up display: zero with leading digits blanked
    check_startup("boot");
    exp_q.push_back({4'b1110, 1'b1, 7'b0000001});
    exp_q.push_back({4'b1101, 1'b1, OFF});
    exp_q.push_back({4'b1011, 1'b1, OFF});
    exp_q.push_back({4'b0111, 1'b1, OFF});
    grab_frame(0);

    // hex letters and a decimal point
    load_word(16'h12AF, 4'b0100);
    exp_q.push_back({4'b1110, 1'b1, 7'b0111000});
    exp_q.push_back({4'b1101, 1'b1, 7'b0001000});
    exp_q.push_back({4'b1011, 1'b0, 7'b0010010});
    exp_q.push_back({4'b0111, 1'b1, 7'b1001111});
    grab_frame(0);

    // leading zeros, with and without suppression
    load_word(16'h0050, 4'b0000);
    exp_q.push_back({4'b1110, 1'b1, 7'b0000001});
    exp_q.push_back({4'b1101, 1'b1, 7'b0100100});
    exp_q.push_back({4'b1011, 1'b1, OFF});
    exp_q.push_back({4'b0111, 1'b1, OFF});
    expb_q.push_back(7'b0000001);
    expb_q.push_back(7'b0100100);
    expb_q.push_back(7'b0000001);
    expb_q.push_back(7'b0000001);
    grab_frame(0);

    // load on the exact wrap cycle bypasses the pending value
    wait_frame();
    repeat (10) @(negedge clk);
    load_word(16'h1111, 4'b0000);
    repeat (20) @(negedge clk);
    load_word(16'h2222, 4'b0000);
    chk("wrap_frame", 16'(fr_a), 16'd1);
    for (int k = 0; k < ND; k++) exp_q.push_back({~(4'b0001 << k), 1'b1, 7'b0010010});
    grab_frame(1);

    // display disabled for 40 cycles
    enable = 1'b0;
    dark = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an_a == 4'hF && seg_a == OFF && dp_a == 1'b1) dark++;
    end
    enable = 1'b1;
    chk("disabled_dark_cycles", 16'(dark), 16'd40);
    grab_frame(0);

    // reset in the middle of a lit slot
    found = 0;
    for (int i = 0; i < 2 * DV && !found; i++) begin
      @(negedge clk);
      found = (an_a != 4'hF);
    end
    chk("show_seen", 16'(found), 16'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", 16'(seg_a), 16'(OFF));
    chk("midrst_an", 16'(an_a), 16'hF);
    chk("midrst_dp", 16'(dp_a), 16'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check_startup("rerst");

    // randomized loads and enable toggling
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) begin
        load_word(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom));
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    enable = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
